secure_alu_pipe: RTL
====================

Name: secure_alu_pipe

Overview:
Parametrised, pipelined successor to the board-level secure ALU. Accepts operand/opcode transactions over a valid/ready handshake, computes the ALU result, applies a selectable encryption stage (none, key XOR, nibble S-box, S-box+XOR), and presents registered results with status flags. Holds a loadable key register. Sits between the switch/button input logic and the LED/display or UART output path.

Parameters:
WIDTH, 8, operand/result/key width; must be a multiple of 4, minimum 8
KEY_RESET, 8'hA5 (zero-extended/truncated to WIDTH), key register value after reset

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input transaction valid
in_ready  out  1  block accepts a transaction this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B
opcode  in  4  ALU operation
enc_mode  in  2  encryption mode for this transaction
key_load  in  1  load key_in into the key register
key_in  in  WIDTH  new key value
out_valid  out  1  out_data/flags valid
out_ready  in  1  downstream accepts the output
out_data  out  WIDTH  encrypted result
out_carry  out  1  carry/borrow/overflow of the ALU op
out_err  out  1  opcode was unsupported

Behaviour:
- Reset (sync, rst=1 at a clk edge): stage-1 valid=0, out_valid=0, out_data=0, out_carry=0, out_err=0, key=KEY_RESET. Any in-flight transaction is discarded.
- Handshake: adv = !out_valid || out_ready; in_ready = adv. Accept when in_valid && in_ready. Both stages shift only on adv. When adv=0, every register holds (no data loss, no duplication). Order is strictly preserved.
- Latency: with out_ready held high, the result appears at out_valid exactly 2 cycles after the accept edge. Throughput: 1 per cycle.
- Stage 1 (registered on accept): ALU result r, carry, err, enc_mode, and a key snapshot.
- Opcodes: 0000 ADD (carry = bit WIDTH); 0001 SUB a-b (carry = borrow, a<b); 0010 AND; 0011 OR; 0101 XOR; 0100 MUL (low WIDTH bits, carry = 1 if any high bit nonzero); 1010 SHL a by b[log2(WIDTH)-1:0]; 1011 SHR logical, same amount. Carry=0 for non-arithmetic ops. Any other opcode: r=0, err=1.
- Stage 2 encryption (applied to r with the snapshot key k):
  - 00: r
  - 01: r ^ k
  - 10: S(r)
  - 11: S(r) ^ k
- S(): each 4-bit nibble is replaced independently with the table 0..F -> C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
- Key register: key_load=1 writes key_in at that edge. The key snapshot is taken at the accept edge from the key value before that edge, so a transaction accepted in the same cycle as key_load uses the old key. key_load is honoured regardless of in_ready.
- Flags travel with data; out_data, out_carry and out_err are stable while out_valid=1 and out_ready=0.

Optional Feature:
KEY_ROLL_EN: when defined, on every accepted transaction with enc_mode != 00, the key register rotates left by 1 bit after the snapshot is taken. key_load in the same cycle takes priority over rotation. When undefined, the key changes only via key_load or reset.

Test Plan:
- Key A5, ADD a=03 b=05, mode 01, out_ready=1 -> out_data=AD, carry=0, out_valid exactly 2 cycles after accept.
- SUB a=03 b=05, mode 00 -> out_data=FE, out_carry=1. Then MUL a=10 b=10 -> out_data=00, out_carry=1.
- ADD 03+05, mode 10 -> out_data=C3. Same operation in mode 11 with key A5 -> 66.
- Issue 3 back-to-back transactions and hold out_ready=0 for 5 cycles -> in_ready=0 while out_valid=1 is held, out_data stays constant, then all 3 results emerge in order with none lost.
- key_load=1 with key_in=3C in the same cycle as accepting ADD 01+01 mode 01 -> result 02^A5=A7. The next ADD 01+01 gives 02^3C=3E. With KEY_ROLL_EN defined, key A5, two mode-01 ADD 00+00 -> results A5, then 4B.
- opcode 1111, mode 00 -> out_data=00, out_err=1. Assert rst with 2 transactions in flight -> next cycle out_valid=0, out_data=0, key=A5, and no stale output afterwards.

Source files
------------

// File: rtl/secure_alu_pipe_if.sv
// Handshake/data bundle for secure_alu_pipe: operand transactions in, encrypted results out.
// Ports: in_valid/in_ready + a, b, opcode, enc_mode; key_load/key_in; out_valid/out_ready + out_data, out_carry, out_err.
// Modports: master drives transactions and consumes results, slave is the ALU pipe itself.
interface secure_alu_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       opcode;
  logic [1:0]       enc_mode;
  logic             key_load;
  logic [WIDTH-1:0] key_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic             out_err;

  modport master (
    output in_valid, a, b, opcode, enc_mode, key_load, key_in, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_err
  );

  modport slave (
    input  in_valid, a, b, opcode, enc_mode, key_load, key_in, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_err
  );
endinterface

// File: rtl/secure_alu_pipe.sv
// Two-stage pipelined ALU with selectable result encryption (none, key XOR, nibble S-box, S-box+XOR).
// Latency: out_valid rises on the second rising edge counting the accept edge; one transaction per cycle.
// Backpressure: in_ready = !out_valid || out_ready; both stages hold while the output is stalled.
// Ports: clk, rst (sync, active-high), bus (secure_alu_pipe_if.slave: input handshake, key load, output handshake).
// Optional: define KEY_ROLL_EN to rotate the key left by one after every accepted encrypting transaction.
module secure_alu_pipe #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] KEY_RESET = WIDTH'(8'hA5)
) (
  input logic              clk,
  input logic              rst,
  secure_alu_pipe_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int NIB = WIDTH / 4;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_MUL = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_SHL = 4'b1010;
  localparam logic [3:0] OP_SHR = 4'b1011;

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
      $error("secure_alu_pipe: WIDTH must be a multiple of 4 and at least 8");
    end
  endgenerate

  // Nibble-wise substitution; every nibble is mapped independently.
  function automatic logic [WIDTH-1:0] sbox(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] o;
    o = '0;
    for (int i = 0; i < NIB; i++) begin
      case (v[4*i +: 4])
        4'h0: o[4*i +: 4] = 4'hC;
        4'h1: o[4*i +: 4] = 4'h5;
        4'h2: o[4*i +: 4] = 4'h6;
        4'h3: o[4*i +: 4] = 4'hB;
        4'h4: o[4*i +: 4] = 4'h9;
        4'h5: o[4*i +: 4] = 4'h0;
        4'h6: o[4*i +: 4] = 4'hA;
        4'h7: o[4*i +: 4] = 4'hD;
        4'h8: o[4*i +: 4] = 4'h3;
        4'h9: o[4*i +: 4] = 4'hE;
        4'hA: o[4*i +: 4] = 4'hF;
        4'hB: o[4*i +: 4] = 4'h8;
        4'hC: o[4*i +: 4] = 4'h4;
        4'hD: o[4*i +: 4] = 4'h7;
        4'hE: o[4*i +: 4] = 4'h1;
        4'hF: o[4*i +: 4] = 4'h2;
      endcase
    end
    return o;
  endfunction

  logic             adv;
  logic             accept;
  logic [WIDTH-1:0] key;

  logic             s1_vld;
  logic [WIDTH-1:0] s1_r;
  logic [WIDTH-1:0] s1_key;
  logic             s1_carry;
  logic             s1_err;
  logic [1:0]       s1_mode;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_carry_q;
  logic             out_err_q;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] prod;
  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   alu_r;
  logic               alu_carry;
  logic               alu_err;
  logic [WIDTH-1:0]   enc_r;

  // A single advance enable for both stages keeps the pipe lossless and in order.
  assign adv          = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && adv;
  assign bus.in_ready = adv;

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_carry = out_carry_q;
  assign bus.out_err   = out_err_q;

  always_comb begin
    sum       = {1'b0, bus.a} + {1'b0, bus.b};
    diff      = {1'b0, bus.a} - {1'b0, bus.b};  // diff[WIDTH] is the borrow (a < b)
    prod      = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};
    shamt     = bus.b[SHW-1:0];
    alu_r     = '0;
    alu_carry = 1'b0;
    alu_err   = 1'b0;
    case (bus.opcode)
      OP_ADD: begin
        alu_r     = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
      end
      OP_SUB: begin
        alu_r     = diff[WIDTH-1:0];
        alu_carry = diff[WIDTH];
      end
      OP_AND: alu_r = bus.a & bus.b;
      OP_OR:  alu_r = bus.a | bus.b;
      OP_XOR: alu_r = bus.a ^ bus.b;
      OP_MUL: begin
        alu_r     = prod[WIDTH-1:0];
        alu_carry = |prod[2*WIDTH-1:WIDTH];
      end
      OP_SHL: alu_r = bus.a << shamt;
      OP_SHR: alu_r = bus.a >> shamt;
      default: alu_err = 1'b1;
    endcase
  end

  // Stage 1: ALU result plus the key as it stood before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_r     <= '0;
      s1_key   <= '0;
      s1_carry <= 1'b0;
      s1_err   <= 1'b0;
      s1_mode  <= 2'b00;
    end else if (adv) begin
      s1_vld <= bus.in_valid;
      if (accept) begin
        s1_r     <= alu_r;
        s1_key   <= key;
        s1_carry <= alu_carry;
        s1_err   <= alu_err;
        s1_mode  <= bus.enc_mode;
      end
    end
  end

  always_comb begin
    enc_r = s1_mode[1] ? sbox(s1_r) : s1_r;
    if (s1_mode[0]) begin
      enc_r = enc_r ^ s1_key;
    end
  end

  // Stage 2: output register; data only reloads on a real transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_carry_q <= 1'b0;
      out_err_q   <= 1'b0;
    end else if (adv) begin
      out_valid_q <= s1_vld;
      if (s1_vld) begin
        out_data_q  <= enc_r;
        out_carry_q <= s1_carry;
        out_err_q   <= s1_err;
      end
    end
  end

  // key_load wins over rotation and does not depend on in_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      key <= KEY_RESET;
    end else if (bus.key_load) begin
      key <= bus.key_in;
`ifdef KEY_ROLL_EN
    end else if (accept && bus.enc_mode != 2'b00) begin
      key <= {key[WIDTH-2:0], key[WIDTH-1]};
`endif
    end
  end
endmodule
